delay_client: RTL and testbench

DELAY_CLIENT -- requirements
Module: delay_client

---
 rtl/delay_client.sv | 251 +++++++++++++++++++++++++
 tb/tb_delay_client.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_client.sv
// delay_client: walks every delay tap through an alloc/read/write request protocol with a delay-line master.
// Optional response watchdog on the read/write waits: define DELAY_CLIENT_WATCHDOG_EN.
module delay_client #(
    parameter int data_width     = 16,
    parameter int n_channels     = 4,
    parameter int size_width     = 12,
    parameter int timeout_cycles = 64
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                enable,
    input  logic                                                cfg_write,
    input  logic [(n_channels > 1 ? $clog2(n_channels) : 1)-1:0] cfg_channel,
    input  logic [size_width-1:0]                               cfg_size,
    input  logic [2*size_width-1:0]                             cfg_delay,
    input  logic                                                cfg_commit,
    input  logic                                                sample_valid,
    input  logic signed [data_width-1:0]                        sample_in,
    input  logic signed [data_width-1:0]                        inc_in,
    output logic [n_channels*data_width-1:0]                    tap_out,
    output logic                                                tap_valid,
    output logic                                                busy,
    output logic                                                alloc_done,
    output logic                                                overrun,
    output logic                                                error,
    output logic [1:0]                                          error_code,
    output logic                                                alloc_req,
    output logic                                                read_req,
    output logic                                                write_req,
    output logic [size_width-1:0]                               alloc_size,
    output logic [2*size_width-1:0]                             alloc_delay,
    output logic [data_width-1:0]                               read_handle,
    output logic [data_width-1:0]                               write_handle,
    output logic [data_width-1:0]                               write_data,
    output logic [data_width-1:0]                               write_inc,
    input  logic [data_width-1:0]                               data_out,
    input  logic                                                read_valid,
    input  logic                                                write_ack,
    input  logic                                                invalid_alloc,
    input  logic                                                invalid_read,
    input  logic                                                invalid_write
);
    localparam int            cw        = (n_channels > 1) ? $clog2(n_channels) : 1;
    localparam logic [cw-1:0] last_chan = cw'(n_channels - 1);

    typedef enum logic [2:0] {
        IDLE, ALLOC, ALLOC_WAIT, READ, READ_WAIT, WRITE, WRITE_WAIT, DONE
    } state_t;

    state_t                  state_reg, state_next;
    logic [cw-1:0]           chan_reg;
    logic                    wait_phase_reg;
    logic                    committed_reg;
    logic                    busy_reg;
    logic                    alloc_done_reg;
    logic                    overrun_reg;
    logic                    error_reg;
    logic [1:0]              error_code_reg;
    logic [data_width-1:0]   sample_reg;
    logic [data_width-1:0]   inc_reg;
    logic [size_width-1:0]   slot_size_reg  [n_channels];
    logic [2*size_width-1:0] slot_delay_reg [n_channels];
    logic [data_width-1:0]   tap_reg        [n_channels];
    logic                    last_hit;
    logic                    commit_ok;
    logic                    sample_ok;
    logic                    wd_expired;

    assign last_hit  = (chan_reg == last_chan);
    assign commit_ok = (state_reg == IDLE) && cfg_commit && !alloc_done_reg && !error_reg;
    assign sample_ok = (state_reg == IDLE) && sample_valid && alloc_done_reg && !error_reg;

`ifdef DELAY_CLIENT_WATCHDOG_EN
    localparam int wdw = $clog2(timeout_cycles + 1);
    logic [wdw-1:0] wd_cnt_reg;

    // Restarts on every entry into a wait state, so each request gets its own budget.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_reg <= '0;
        end else if (enable) begin
            if (state_reg == READ_WAIT || state_reg == WRITE_WAIT)
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
            else
                wd_cnt_reg <= '0;
        end
    end

    assign wd_expired = (state_reg == READ_WAIT || state_reg == WRITE_WAIT) &&
                        (wd_cnt_reg == wdw'(timeout_cycles - 1));
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        alloc_req  = 1'b0;
        read_req   = 1'b0;
        write_req  = 1'b0;
        tap_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (commit_ok)
                    state_next = ALLOC;
                else if (sample_ok)
                    state_next = READ;
            end
            ALLOC: begin
                alloc_req  = 1'b1;
                state_next = ALLOC_WAIT;
            end
            ALLOC_WAIT: begin
                if (invalid_alloc)
                    state_next = IDLE;
                else if (wait_phase_reg)
                    state_next = last_hit ? IDLE : ALLOC;
            end
            READ: begin
                read_req   = 1'b1;
                state_next = READ_WAIT;
            end
            READ_WAIT: begin
                if (invalid_read)
                    state_next = IDLE;
                else if (read_valid)
                    state_next = WRITE;
                else if (wd_expired)
                    state_next = IDLE;
            end
            WRITE: begin
                write_req  = 1'b1;
                state_next = WRITE_WAIT;
            end
            WRITE_WAIT: begin
                if (invalid_write)
                    state_next = IDLE;
                else if (write_ack)
                    state_next = last_hit ? DONE : READ;
                else if (wd_expired)
                    state_next = IDLE;
            end
            DONE: begin
                tap_valid  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            chan_reg       <= '0;
            wait_phase_reg <= 1'b0;
            committed_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            alloc_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            error_reg      <= 1'b0;
            error_code_reg <= 2'd0;
            sample_reg     <= '0;
            inc_reg        <= '0;
        end else if (enable) begin
            state_reg      <= state_next;
            wait_phase_reg <= (state_reg == ALLOC_WAIT) && !wait_phase_reg;
            if (commit_ok) begin
                chan_reg      <= '0;
                committed_reg <= 1'b1;
            end
            if (sample_ok) begin
                sample_reg <= sample_in;
                inc_reg    <= inc_in;
                chan_reg   <= '0;
                busy_reg   <= 1'b1;
            end
            if (sample_valid && !sample_ok)
                overrun_reg <= 1'b1;
            case (state_reg)
                ALLOC_WAIT: begin
                    if (invalid_alloc) begin
                        error_reg      <= 1'b1;
                        error_code_reg <= 2'd1;
                    end else if (wait_phase_reg) begin
                        if (last_hit)
                            alloc_done_reg <= 1'b1;
                        else
                            chan_reg <= chan_reg + 1'b1;
                    end
                end
                READ_WAIT: begin
                    if (invalid_read || (!read_valid && wd_expired)) begin
                        error_reg      <= 1'b1;
                        error_code_reg <= 2'd2;
                        busy_reg       <= 1'b0;
                    end
                end
                WRITE_WAIT: begin
                    if (invalid_write || (!write_ack && wd_expired)) begin
                        error_reg      <= 1'b1;
                        error_code_reg <= 2'd3;
                        busy_reg       <= 1'b0;
                    end else if (write_ack && !last_hit) begin
                        chan_reg <= chan_reg + 1'b1;
                    end
                end
                DONE:    busy_reg <= 1'b0;
                default: ;
            endcase
        end
    end

    // Slot table is frozen once allocation has been committed.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < n_channels; i++) begin
                slot_size_reg[i]  <= '0;
                slot_delay_reg[i] <= '0;
                tap_reg[i]        <= '0;
            end
        end else if (enable) begin
            for (int i = 0; i < n_channels; i++) begin
                if (cfg_write && !committed_reg && cfg_channel == cw'(i)) begin
                    slot_size_reg[i]  <= cfg_size;
                    slot_delay_reg[i] <= cfg_delay;
                end
                if (state_reg == READ_WAIT && read_valid && !invalid_read && chan_reg == cw'(i))
                    tap_reg[i] <= data_out;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < n_channels; gi++) begin : g_tap
            assign tap_out[gi*data_width +: data_width] = tap_reg[gi];
        end
    endgenerate

    assign alloc_size   = slot_size_reg[chan_reg];
    assign alloc_delay  = slot_delay_reg[chan_reg];
    assign read_handle  = data_width'(chan_reg);
    assign write_handle = data_width'(chan_reg);
    assign write_data   = sample_reg;
    assign write_inc    = inc_reg;
    assign busy         = busy_reg;
    assign alloc_done   = alloc_done_reg;
    assign overrun      = overrun_reg;
    assign error        = error_reg;
    assign error_code   = error_code_reg;

endmodule

// File: tb/tb_delay_client.sv
// Randomized bench for delay_client: a behavioural delay-line master plus per-sample transaction model.
module tb_delay_client;
    localparam int DW = 16;
    localparam int N  = 4;
    localparam int SW = 12;
    localparam int CW = 2;
    localparam int TO = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, enable, cfg_write, cfg_commit, sample_valid;
    logic [CW-1:0]     cfg_channel;
    logic [SW-1:0]     cfg_size;
    logic [2*SW-1:0]   cfg_delay;
    logic [DW-1:0]     sample_in, inc_in;
    logic [N*DW-1:0]   tap_out;
    logic              tap_valid, busy, alloc_done, overrun, error;
    logic [1:0]        error_code;
    logic              alloc_req, read_req, write_req;
    logic [SW-1:0]     alloc_size;
    logic [2*SW-1:0]   alloc_delay;
    logic [DW-1:0]     read_handle, write_handle, write_data, write_inc, data_out;
    logic              read_valid, write_ack, invalid_alloc, invalid_read, invalid_write;

    delay_client #(
        .data_width(DW), .n_channels(N), .size_width(SW), .timeout_cycles(TO)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .cfg_write(cfg_write),
        .cfg_channel(cfg_channel), .cfg_size(cfg_size), .cfg_delay(cfg_delay),
        .cfg_commit(cfg_commit), .sample_valid(sample_valid), .sample_in(sample_in),
        .inc_in(inc_in), .tap_out(tap_out), .tap_valid(tap_valid), .busy(busy),
        .alloc_done(alloc_done), .overrun(overrun), .error(error), .error_code(error_code),
        .alloc_req(alloc_req), .read_req(read_req), .write_req(write_req),
        .alloc_size(alloc_size), .alloc_delay(alloc_delay), .read_handle(read_handle),
        .write_handle(write_handle), .write_data(write_data), .write_inc(write_inc),
        .data_out(data_out), .read_valid(read_valid), .write_ack(write_ack),
        .invalid_alloc(invalid_alloc), .invalid_read(invalid_read), .invalid_write(invalid_write)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Master-side model state, shared with the stimulus process.
    logic [63:0]   rw_log    [$];
    logic [63:0]   alloc_log [$];
    logic [DW-1:0] taps_exp  [N];
    int lat_read = 1, lat_write = 1, fail_alloc_idx = -1;
    bit fail_read = 0, fail_write = 0, hold_read = 0, hold_write = 0, fixed_data = 0;
    bit ov_exp = 0;

    function automatic logic [63:0] pack_rw(input int kind, input logic [DW-1:0] h,
                                            input logic [DW-1:0] d, input logic [DW-1:0] i);
        return {14'h0, 2'(kind), h, d, i};
    endfunction

    function automatic logic [63:0] exp_taps();
        logic [63:0] r;
        r = '0;
        for (int c = 0; c < N; c++) r[c*DW +: DW] = taps_exp[c];
        return r;
    endfunction

    // Behavioural delay-line master: hands out handles in allocation order, answers after a latency.
    initial begin : master
        int pend_cnt, pend_kind, alloc_cnt;
        int pend_handle;
        logic [DW-1:0] pend_data;
        bit outstanding;
        pend_cnt = 0; pend_kind = 0; alloc_cnt = 0; pend_handle = 0; pend_data = '0; outstanding = 0;
        read_valid = 0; write_ack = 0; invalid_alloc = 0; invalid_read = 0; invalid_write = 0;
        data_out = '0;
        forever begin
            @(negedge clk);
            read_valid = 0; write_ack = 0; invalid_alloc = 0; invalid_read = 0; invalid_write = 0;
            if (reset) begin
                pend_cnt = 0; outstanding = 0; alloc_cnt = 0;
            end else begin
                if (pend_cnt > 0) begin
                    pend_cnt--;
                    if (pend_cnt == 0) begin
                        outstanding = 0;
                        case (pend_kind)
                            0: invalid_alloc = 1;
                            1: begin
                                read_valid = 1;
                                if (fail_read) begin
                                    invalid_read = 1;
                                    data_out = 16'hBEEF;
                                end else begin
                                    data_out = pend_data;
                                    taps_exp[pend_handle] = pend_data;
                                end
                            end
                            default: begin
                                if (fail_write) invalid_write = 1;
                                else write_ack = 1;
                            end
                        endcase
                    end
                end
                if (alloc_req) begin
                    alloc_log.push_back({28'h0, alloc_size, alloc_delay});
                    if (alloc_cnt == fail_alloc_idx) begin
                        pend_kind = 0; pend_cnt = 1;
                    end
                    alloc_cnt++;
                end
                if (read_req) begin
                    check_eq("single_outstanding_rd", 64'(outstanding), 0);
                    check_eq("read_handle_allocated", 64'(int'(read_handle) < alloc_cnt), 1);
                    rw_log.push_back(pack_rw(1, read_handle, '0, '0));
                    pend_handle = int'(read_handle) % N;
                    pend_data = fixed_data ? 16'(16'h0111 * (pend_handle + 1)) : 16'($urandom);
                    outstanding = 1;
                    if (!hold_read) begin pend_kind = 1; pend_cnt = lat_read; end
                end
                if (write_req) begin
                    check_eq("single_outstanding_wr", 64'(outstanding), 0);
                    rw_log.push_back(pack_rw(2, write_handle, write_data, write_inc));
                    outstanding = 1;
                    if (!hold_write) begin pend_kind = 2; pend_cnt = lat_write; end
                end
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_alloc_req"},  64'(alloc_req), 0);
        check_eq({tag, "_read_req"},   64'(read_req), 0);
        check_eq({tag, "_write_req"},  64'(write_req), 0);
        check_eq({tag, "_tap_out"},    tap_out, 0);
        check_eq({tag, "_tap_valid"},  64'(tap_valid), 0);
        check_eq({tag, "_busy"},       64'(busy), 0);
        check_eq({tag, "_alloc_done"}, 64'(alloc_done), 0);
        check_eq({tag, "_overrun"},    64'(overrun), 0);
        check_eq({tag, "_error"},      64'(error), 0);
        check_eq({tag, "_error_code"}, 64'(error_code), 0);
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        fail_read = 0; fail_write = 0; hold_read = 0; hold_write = 0; fail_alloc_idx = -1;
        rw_log.delete(); alloc_log.delete(); ov_exp = 0;
        for (int c = 0; c < N; c++) taps_exp[c] = '0;
    endtask

    task automatic do_alloc(input int fail_idx);
        int cyc;
        logic [63:0] e;
        fail_alloc_idx = fail_idx;
        alloc_log.delete();
        for (int c = 0; c < N; c++) begin
            cfg_write = 1; cfg_channel = CW'(c);
            cfg_size = SW'(100 * (c + 1)); cfg_delay = 24'(24'h1000 * (c + 1));
            @(negedge clk);
        end
        cfg_write = 0; cfg_commit = 1;
        @(negedge clk);
        cfg_commit = 0;
        cyc = 0;
        while (!alloc_done && !error && cyc < 100) begin @(negedge clk); cyc++; end
        check_eq("alloc_wait_bound", 64'(cyc < 100), 1);
        if (fail_idx < 0) begin
            check_eq("alloc_cycles", 64'(cyc), 64'(3 * N));
            check_eq("alloc_done", 64'(alloc_done), 1);
            check_eq("alloc_no_error", 64'(error), 0);
            check_eq("alloc_count", 64'(alloc_log.size()), 64'(N));
            for (int c = 0; c < N; c++) begin
                e = {28'h0, SW'(100 * (c + 1)), 24'(24'h1000 * (c + 1))};
                if (c < alloc_log.size()) check_eq("alloc_entry", alloc_log[c], e);
            end
            $display("[TB] alloc %0d slots in %0d cycles", alloc_log.size(), cyc);
        end else begin
            repeat (3) @(negedge clk);
            check_eq("alloc_err_error", 64'(error), 1);
            check_eq("alloc_err_code", 64'(error_code), 1);
            check_eq("alloc_err_done", 64'(alloc_done), 0);
            check_eq("alloc_err_count", 64'(alloc_log.size()), 64'(fail_idx + 1));
            $display("[TB] alloc rejected at slot %0d, error_code=%0d", fail_idx, error_code);
        end
    endtask

    task automatic run_sample(input logic [DW-1:0] s, input logic [DW-1:0] inc, input bit inject);
        int cyc;
        rw_log.delete();
        lat_read = $urandom_range(1, 4);
        lat_write = $urandom_range(1, 4);
        sample_in = s; inc_in = inc; sample_valid = 1;
        @(negedge clk);
        sample_valid = 0;
        check_eq("busy_after_accept", 64'(busy), 1);
        if (inject) begin
            @(negedge clk);
            sample_in = ~s; sample_valid = 1;
            @(negedge clk);
            sample_valid = 0;
            ov_exp = 1;
        end
        cyc = 0;
        while (!tap_valid && cyc < 400) begin @(negedge clk); cyc++; end
        check_eq("tap_valid_bound", 64'(cyc < 400), 1);
        check_eq("tap_out", tap_out, exp_taps());
        @(negedge clk);
        check_eq("tap_valid_single", 64'(tap_valid), 0);
        check_eq("busy_cleared", 64'(busy), 0);
        check_eq("req_count", 64'(rw_log.size()), 64'(2 * N));
        for (int c = 0; c < N; c++) begin
            if (2 * c < rw_log.size())
                check_eq("read_entry", rw_log[2*c], pack_rw(1, DW'(c), '0, '0));
            if (2 * c + 1 < rw_log.size())
                check_eq("write_entry", rw_log[2*c+1], pack_rw(2, DW'(c), s, inc));
        end
        check_eq("overrun", 64'(overrun), 64'(ov_exp));
        $display("[TB] sample 0x%04h inc 0x%04h -> taps 0x%016h (%0d reqs)", s, inc, tap_out, rw_log.size());
    endtask

    initial begin : global_guard
        #1000000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int cyc;
        logic [63:0] tap_before;
        reset = 1; enable = 1; cfg_write = 0; cfg_commit = 0; sample_valid = 0;
        cfg_channel = '0; cfg_size = '0; cfg_delay = '0; sample_in = '0; inc_in = '0;
        for (int c = 0; c < N; c++) taps_exp[c] = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 0;

        // A sample before allocation is dropped and flagged.
        sample_in = 16'h5555; sample_valid = 1;
        @(negedge clk);
        sample_valid = 0;
        check_eq("pre_alloc_overrun", 64'(overrun), 1);
        check_eq("pre_alloc_busy", 64'(busy), 0);
        repeat (3) @(negedge clk);
        check_eq("pre_alloc_no_req", 64'(rw_log.size()), 0);
        do_reset();
        check_eq("overrun_cleared", 64'(overrun), 0);

        do_alloc(-1);
        fixed_data = 1;
        run_sample(16'h1234, 16'h0010, 1);
        fixed_data = 0;
        for (int k = 0; k < 12; k++) run_sample(16'($urandom), 16'($urandom), 0);

        // enable low freezes the block: a sample is neither accepted nor served.
        rw_log.delete();
        enable = 0; sample_valid = 1; sample_in = 16'h7777;
        @(negedge clk);
        sample_valid = 0;
        repeat (3) @(negedge clk);
        check_eq("frozen_busy", 64'(busy), 0);
        check_eq("frozen_no_req", 64'(rw_log.size()), 0);
        enable = 1;
        @(negedge clk);
        run_sample(16'h0F0F, 16'h0001, 0);

        // invalid_read together with read_valid: error wins, tap untouched.
        rw_log.delete();
        fail_read = 1;
        tap_before = tap_out;
        sample_in = 16'hAAAA; sample_valid = 1;
        @(negedge clk);
        sample_valid = 0;
        cyc = 0;
        while (!error && cyc < 100) begin @(negedge clk); cyc++; end
        check_eq("rd_err_bound", 64'(cyc < 100), 1);
        check_eq("rd_err_code", 64'(error_code), 2);
        check_eq("rd_err_busy", 64'(busy), 0);
        check_eq("rd_err_tap_kept", tap_out, tap_before);
        fail_read = 0;
        rw_log.delete();
        sample_valid = 1;
        @(negedge clk);
        sample_valid = 0;
        repeat (10) @(negedge clk);
        check_eq("no_req_after_error", 64'(rw_log.size()), 0);
        check_eq("error_sticky", 64'(error), 1);
        $display("[TB] read rejected, error_code=%0d", error_code);

        // invalid_write
        do_reset();
        do_alloc(-1);
        fail_write = 1;
        sample_in = 16'h4321; inc_in = 16'h0002; sample_valid = 1;
        @(negedge clk);
        sample_valid = 0;
        cyc = 0;
        while (!error && cyc < 100) begin @(negedge clk); cyc++; end
        check_eq("wr_err_bound", 64'(cyc < 100), 1);
        check_eq("wr_err_code", 64'(error_code), 3);
        check_eq("wr_err_tap", tap_out, exp_taps());
        $display("[TB] write rejected, error_code=%0d", error_code);

        // invalid_alloc one cycle after the second alloc_req
        do_reset();
        do_alloc(1);

        // read response withheld
        do_reset();
        do_alloc(-1);
        hold_read = 1;
        sample_in = 16'h0101; sample_valid = 1;
        @(negedge clk);
        sample_valid = 0;
        cyc = 0;
        while (!error && cyc < 150) begin @(negedge clk); cyc++; end
`ifdef DELAY_CLIENT_WATCHDOG_EN
        check_eq("wd_error", 64'(error), 1);
        check_eq("wd_code", 64'(error_code), 2);
        check_eq("wd_cycles", 64'(cyc), 64'(TO + 1));
`else
        check_eq("hold_no_error", 64'(error), 0);
        check_eq("hold_busy", 64'(busy), 1);
        check_eq("hold_one_req", 64'(rw_log.size()), 1);
`endif
        $display("[TB] withheld read: error=%0d after %0d cycles", error, cyc);

        // reset during WRITE_WAIT
        do_reset();
        do_alloc(-1);
        hold_write = 1;
        sample_in = 16'h3C3C; sample_valid = 1;
        @(negedge clk);
        sample_valid = 0;
        cyc = 0;
        while (rw_log.size() < 2 && cyc < 50) begin @(negedge clk); cyc++; end
        check_eq("write_req_bound", 64'(cyc < 50), 1);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        check_reset_state("mid_reset");
        @(negedge clk);
        reset = 0;
        hold_write = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("post_reset_no_req", 64'({alloc_req, read_req, write_req}), 0);
        end
        $display("[TB] reset during write wait abandoned transaction");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
